// File: rtl/hash_search_pkg.sv
// Shared definitions for the multi-lane nonce search: FSM states, round constants
// and the hash round/seed functions used by both the lanes and any reference model.
package hash_search_pkg;

  localparam int HW_MAX = 64;  // widest supported HASH_W / NONCE_W
  typedef logic [HW_MAX-1:0] word_t;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DRAIN, S_DONE} state_t;

  function automatic int clog2_cnt(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic word_t wmask(input int w);
    return ~word_t'(0) >> (HW_MAX - w);
  endfunction

  function automatic word_t k_const(input int i);
    case (i % 8)
      0: return 64'h9E3779B97F4A7C15;
      1: return 64'hC2B2AE3D27D4EB4F;
      2: return 64'h165667B19E3779F9;
      3: return 64'h85EBCA77C2B2AE63;
      4: return 64'h27D4EB2F165667C5;
      5: return 64'hFF51AFD7ED558CCD;
      6: return 64'hC4CEB9FE1A85EC53;
      default: return 64'h5A827999_6ED9EBA1;
    endcase
  endfunction

  // Bounty XOR nonce, with nonce bits above HASH_W folded down chunk by chunk.
  function automatic word_t seed(input word_t bounty, input word_t nonce, input int nw, input int w);
    word_t x;
    x = bounty;
    for (int c = 0; c < nw; c += w) x ^= (nonce >> c);
    return x & wmask(w);
  endfunction

  function automatic word_t hash_round(input word_t x, input int i, input int w);
    word_t xm, rl;
    xm = x & wmask(w);
    rl = ((xm << 5) | (xm >> (w - 5))) & wmask(w);
    return (rl + (xm ^ k_const(i))) & wmask(w);
  endfunction

endpackage

// File: rtl/hash_lane.sv
// One hash lane: PIPE registered rounds; carries nonce and valid alongside the hash.
module hash_lane
  import hash_search_pkg::*;
#(
  parameter int HASH_W  = 24,
  parameter int NONCE_W = 32,
  parameter int TGT_W   = 8,
  parameter int PIPE    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [NONCE_W-1:0] i_nonce,
  input  logic [HASH_W-1:0]  i_bounty,
  input  logic [TGT_W-1:0]   i_target,
  output logic               o_valid,
  output logic [NONCE_W-1:0] o_nonce,
  output logic [HASH_W-1:0]  o_hash,
  output logic               o_hit
);

  logic [PIPE:1]        r_vld_pipe;
  logic [HASH_W-1:0]    w_x0;
  logic [HASH_W-1:0]    w_xin [1:PIPE];
  logic [NONCE_W-1:0]   w_nin [1:PIPE];
  logic [HASH_W-1:0]    r_x   [1:PIPE];
  logic [NONCE_W-1:0]   r_n   [1:PIPE];

  assign w_x0 = HASH_W'(seed(word_t'(i_bounty), word_t'(i_nonce), NONCE_W, HASH_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= i_valid;
      for (int s = 2; s <= PIPE; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
    end
  end

  for (genvar s = 1; s <= PIPE; s++) begin : g_stg
    if (s == 1) begin : g_first
      assign w_xin[s] = w_x0;
      assign w_nin[s] = i_nonce;
    end else begin : g_next
      assign w_xin[s] = r_x[s-1];
      assign w_nin[s] = r_n[s-1];
    end
    // Data stages need no reset: the valid pipe alone qualifies them.
    always_ff @(posedge clk) begin
      r_x[s] <= HASH_W'(hash_round(word_t'(w_xin[s]), s - 1, HASH_W));
      r_n[s] <= w_nin[s];
    end
  end

  assign o_valid = r_vld_pipe[PIPE];
  assign o_nonce = r_n[PIPE];
  assign o_hash  = r_x[PIPE];
  assign o_hit   = r_x[PIPE][HASH_W-1 -: TGT_W] < i_target;

endmodule

// File: rtl/hash_search_multi.sv
// Multi-lane nonce search: issues LANES nonces per cycle, keeps the lowest num_req
// hits in a small FIFO drained by valid/ready, and reports completion via fin.
module hash_search_multi
  import hash_search_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 24,
  parameter int TGT_W     = 8,
  parameter int MAX_FOUND = 4,
  parameter int PIPE      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [HASH_W-1:0]              bounty_in,
  input  logic [TGT_W-1:0]               target,
  input  logic [$clog2(MAX_FOUND+1)-1:0] num_req,
  output logic                           busy,
  output logic [NONCE_W-1:0]             nonce,
  output logic                           found_valid,
  input  logic                           found_ready,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [HASH_W-1:0]              found_hash,
  output logic [$clog2(MAX_FOUND+1)-1:0] found_count,
  output logic                           fin,
  output logic                           exhausted
);

  localparam int CW    = $clog2(MAX_FOUND + 1);
  localparam int AW    = (MAX_FOUND > 1) ? $clog2(MAX_FOUND) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int IW    = $clog2(PIPE + 2);

  state_t                          r_state, w_state_nxt;
  logic [HASH_W-1:0]               r_bounty;
  logic [TGT_W-1:0]                r_target;
  logic [CW-1:0]                   r_req, r_count, r_rd, w_req_in, w_nacc, w_count_nxt;
  logic [NONCE_W-1:0]              r_base, w_base_nxt;
  logic [IW-1:0]                   r_infl, w_infl_nxt;
  logic                            w_start, w_issue, w_take, w_pop;
  logic [LANES-1:0]                w_lv, w_lhit, w_acc;
  logic [LANES-1:0][NONCE_W-1:0]   w_ln;
  logic [LANES-1:0][HASH_W-1:0]    w_lh;
  logic [LANES-1:0][AW-1:0]        w_slot;
  logic [NONCE_W-1:0]              r_mem_n [DEPTH];
  logic [HASH_W-1:0]               r_mem_h [DEPTH];
  logic [AW-1:0]                   w_rd_idx;

  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue     = (r_state == S_SEARCH);
  assign w_take      = (r_state == S_SEARCH) || (r_state == S_DRAIN);
  assign w_base_nxt  = r_base + NONCE_W'(LANES);
  assign w_infl_nxt  = r_infl + IW'(w_issue) - IW'(w_lv[0]);
  assign w_count_nxt = r_count + w_nacc;
  assign w_req_in    = (num_req == '0) ? CW'(1) :
                       ((num_req > CW'(MAX_FOUND)) ? CW'(MAX_FOUND) : num_req);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hash_lane #(.HASH_W(HASH_W), .NONCE_W(NONCE_W), .TGT_W(TGT_W), .PIPE(PIPE)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_valid  (w_issue),
      .i_nonce  (r_base + NONCE_W'(l)),
      .i_bounty (r_bounty),
      .i_target (r_target),
      .o_valid  (w_lv[l]),
      .o_nonce  (w_ln[l]),
      .o_hash   (w_lh[l]),
      .o_hit    (w_lhit[l])
    );
  end

  // Compact retiring hits in lane order; the FIFO slot is the running hit count,
  // since the FIFO is emptied on every start and never holds more than req entries.
  always_comb begin
    int n, room;
    n      = 0;
    room   = int'(r_req) - int'(r_count);
    w_acc  = '0;
    w_slot = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_take && w_lv[l] && w_lhit[l] && n < room) begin
        w_acc[l]  = 1'b1;
        w_slot[l] = AW'(int'(r_count) + n);
        n++;
      end
    end
    w_nacc = CW'(n);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_SEARCH;
      S_SEARCH:       if (w_count_nxt == r_req || w_base_nxt == '0) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (w_infl_nxt == '0) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bounty <= '0;
      r_target <= '0;
      r_req    <= '0;
      r_base   <= '0;
      r_count  <= '0;
      r_rd     <= '0;
      r_infl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_infl  <= w_infl_nxt;
      if (w_start) begin
        r_bounty <= bounty_in;
        r_target <= target;
        r_req    <= w_req_in;
        r_base   <= '0;
        r_count  <= '0;
        r_rd     <= '0;
      end else begin
        if (w_issue) r_base <= w_base_nxt;
        r_count <= w_count_nxt;
        if (w_pop) r_rd <= r_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_acc[l]) begin
        r_mem_n[w_slot[l]] <= w_ln[l];
        r_mem_h[w_slot[l]] <= w_lh[l];
      end
    end
  end

  assign w_rd_idx    = r_rd[AW-1:0];
  assign found_valid = (r_rd < r_count);
  assign w_pop       = found_valid && found_ready;
  assign found_nonce = found_valid ? r_mem_n[w_rd_idx] : '0;
  assign found_hash  = found_valid ? r_mem_h[w_rd_idx] : '0;
  assign found_count = r_count;
  assign busy        = w_take;
  assign nonce       = r_base;
  assign fin         = (r_state == S_DONE);
  assign exhausted   = fin && (r_count < r_req);

endmodule

// File: tb/tb_hash_search_multi.sv
// Directed bench for hash_search_multi with NONCE_W=8, LANES=4, PIPE=3.
module tb_hash_search_multi;
  import hash_search_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] bounty_in = '0;
  logic [7:0]  target = '0;
  logic [2:0]  num_req = '0;
  logic        busy, found_valid, found_ready, fin, exhausted;
  logic [7:0]  nonce, found_nonce;
  logic [23:0] found_hash;
  logic [2:0]  found_count;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_n [4];
  int          exp_cnt;
  logic [23:0] cur_b;

  hash_search_multi #(.LANES(4), .NONCE_W(8), .HASH_W(24), .TGT_W(8), .MAX_FOUND(4), .PIPE(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bounty_in(bounty_in), .target(target),
    .num_req(num_req), .busy(busy), .nonce(nonce), .found_valid(found_valid),
    .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash),
    .found_count(found_count), .fin(fin), .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] mhash(input logic [7:0] n, input logic [23:0] b);
    word_t x;
    x = seed(word_t'(b), word_t'(n), 8, 24);
    for (int i = 0; i < 3; i++) x = hash_round(x, i, 24);
    return x[23:0];
  endfunction

  // Launch a search, follow it to fin, and check timing and status against the model.
  task automatic run(input logic [23:0] b, input logic [7:0] t, input logic [2:0] nr, input bit spur);
    int req, nx, gf, gl, fv, fin_n, exp_fin, exp_fv, exp_base;
    logic [23:0] h;
    req = (nr == 0) ? 1 : ((nr > 4) ? 4 : int'(nr));
    nx = 0;
    for (int n = 0; n < 256; n++) begin
      h = mhash(8'(n), b);
      if (nx < req && h[23:16] < t) begin
        exp_n[nx] = 8'(n);
        nx++;
      end
    end
    gf = (nx > 0) ? int'(exp_n[0]) / 4 : -1;
    gl = (nx > 0) ? int'(exp_n[nx-1]) / 4 : -1;
    cur_b = b;
    exp_cnt = nx;

    @(negedge clk);
    bounty_in = b; target = t; num_req = nr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_valid", found_valid, 0);
    check("busy", busy, 1);
    check("count0", found_count, 0);
    fv = -1; fin_n = -1;
    for (int k = 0; k < 400; k++) begin
      if (spur && k == 1) begin
        start = 1'b1; bounty_in = ~b; target = 8'h00; num_req = 3'd4;
      end
      if (spur && k == 2) begin
        start = 1'b0;
        check("spur_nonce", nonce, 8);
      end
      if (found_valid && fv < 0) fv = k;
      if (fin) begin
        fin_n = k;
        break;
      end
      @(negedge clk);
    end
    exp_fin  = (nx == req) ? gl + 7 : 67;
    exp_fv   = (nx > 0) ? gf + 4 : -1;
    exp_base = (nx == req) ? ((gl + 4) * 4) % 256 : 0;
    check("fin_cycle", fin_n, exp_fin);
    check("first_valid", fv, exp_fv);
    check("found_count", found_count, nx);
    check("exhausted", exhausted, (nx < req) ? 1 : 0);
    check("base", nonce, exp_base);
    check("idle_busy", busy, 0);
  endtask

  task automatic drain(input int nx);
    for (int i = 0; i < nx; i++) begin
      check("pop_valid", found_valid, 1);
      check("pop_nonce", found_nonce, exp_n[i]);
      check("pop_hash", found_hash, mhash(exp_n[i], cur_b));
      found_ready = 1'b1;
      @(negedge clk);
    end
    check("fifo_empty", found_valid, 0);
    found_ready = 1'b0;
  endtask

  initial begin
    found_ready = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_valid", found_valid, 0);
    check("rst_count", found_count, 0);
    check("rst_nonce", nonce, 0);
    check("rst_exh", exhausted, 0);
    check("rst_fnonce", found_nonce, 0);
    @(negedge clk);
    reset = 1'b0;

    // lowest three hits, held unread until fin, then popped one per cycle
    run(24'hA5C3F1, 8'h80, 3'd3, 1'b0);
    drain(exp_cnt);

    // leave entries unread; the next start must discard them (target 0: no hits, wrap)
    run(24'hA5C3F1, 8'h80, 3'd3, 1'b0);
    check("unread_valid", found_valid, 1);
    run(24'h123456, 8'h00, 3'd2, 1'b0);
    check("t0_fin", fin, 1);

    // near-all hit: only the first two lanes of group 0 survive
    run(24'hA5C3F1, 8'hFF, 3'd2, 1'b0);
    drain(exp_cnt);

    // reset mid-search
    @(negedge clk);
    bounty_in = 24'hA5C3F1; target = 8'h80; num_req = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_nonce", nonce, 0);
    check("mrst_count", found_count, 0);
    check("mrst_fin", fin, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_valid", found_valid, 0);
    check("post_count", found_count, 0);
    check("post_busy", busy, 0);
    run(24'hA5C3F1, 8'h80, 3'd3, 1'b0);
    drain(exp_cnt);

    // num_req=0 acts as 1; a start pulse while busy is ignored
    run(24'h5A5A5A, 8'h80, 3'd0, 1'b1);
    drain(exp_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
